// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator with eight display modes
// A prescaler paces pattern steps; hold freezes it, and a change of choose restarts the pattern.
module led_pattern_gen #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       choose,
   input  logic             hold,
   output logic [WIDTH-1:0] LED,
   output logic             step
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] PAT_ZERO = '0;
   localparam logic [WIDTH-1:0] PAT_ONES = '1;
   localparam logic [WIDTH-1:0] PAT_LSB  = WIDTH'(1);
   localparam logic [WIDTH-1:0] PAT_MSB  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      MODE_OFF   = 3'd0,
      MODE_ROTL  = 3'd1,
      MODE_ROTR  = 3'd2,
      MODE_BIN   = 3'd3,
      MODE_BLINK = 3'd4,
      MODE_PING  = 3'd5,
      MODE_FILL  = 3'd6,
      MODE_GRAY  = 3'd7
   } mode_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   logic [2:0]       choose_q, choose_d;
   logic [WIDTH-1:0] led_q, led_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] b_q, b_d;
   dir_t             dir_q, dir_d;
   logic             step_q, step_d;

   logic             mode_change;
   logic             tick;
   logic [WIDTH-1:0] shl, shr, b_inc;

   function automatic logic [WIDTH-1:0] initial_pattern(input logic [2:0] mode);
      case (mode_t'(mode))
         MODE_ROTL:  return PAT_LSB;
         MODE_ROTR:  return PAT_MSB;
         MODE_BLINK: return PAT_ONES;
         MODE_PING:  return PAT_LSB;
         default:    return PAT_ZERO;
      endcase
   endfunction

   assign mode_change = (choose != choose_q);
   assign tick        = !mode_change && !hold && (cnt_q == CNT_MAX);
   assign shl         = {led_q[WIDTH-2:0], 1'b0};
   assign shr         = {1'b0, led_q[WIDTH-1:1]};
   assign b_inc       = b_q + PAT_LSB;

   always_comb begin
      choose_d = choose;
      led_d    = led_q;
      cnt_d    = cnt_q;
      b_d      = b_q;
      dir_d    = dir_q;
      step_d   = 1'b0;

      if (mode_change) begin
         led_d = initial_pattern(choose);
         cnt_d = CNT_ZERO;
         b_d   = PAT_ZERO;
         dir_d = DIR_LEFT;
      end else if (!hold) begin
         if (tick) begin
            cnt_d  = CNT_ZERO;
            step_d = 1'b1;
            case (mode_t'(choose_q))
               MODE_OFF:   led_d = PAT_ZERO;
               MODE_ROTL:  led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
               MODE_ROTR:  led_d = {led_q[0], led_q[WIDTH-1:1]};
               MODE_BIN:   led_d = led_q + PAT_LSB;
               MODE_BLINK: led_d = ~led_q;
               MODE_PING: begin
                  // Reverse as soon as an end bit is reached so each end shows for one step.
                  if (dir_q == DIR_LEFT) begin
                     led_d = shl;
                     if (shl[WIDTH-1]) dir_d = DIR_RIGHT;
                  end else begin
                     led_d = shr;
                     if (shr[0]) dir_d = DIR_LEFT;
                  end
               end
               MODE_FILL:  led_d = (led_q == PAT_ONES) ? PAT_ZERO : {led_q[WIDTH-2:0], 1'b1};
               MODE_GRAY: begin
                  b_d   = b_inc;
                  led_d = b_inc ^ (b_inc >> 1);
               end
               default:    led_d = PAT_ZERO;
            endcase
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         choose_q <= 3'd0;
         led_q    <= PAT_ZERO;
         cnt_q    <= CNT_ZERO;
         b_q      <= PAT_ZERO;
         dir_q    <= DIR_LEFT;
         step_q   <= 1'b0;
      end else begin
         choose_q <= choose_d;
         led_q    <= led_d;
         cnt_q    <= cnt_d;
         b_q      <= b_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
      end
   end

   assign LED  = led_q;
   assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - bench for led_pattern_gen (DIV=2 and DIV=1 instances)
module tb_led_pattern_gen;

   logic       clk;
   logic       rst;
   logic [2:0] choose;
   logic       hold;
   logic [7:0] led_a, led_b;
   logic       step_a, step_b;

   int  vectors     = 0;
   int  miscompares = 0;
   bit  chk_en      = 0;

   int  divs [2] = '{2, 1};
   int  m_k  [2];
   int  m_cnt[2];
   bit  m_step[2];
   int  m_choose_q;

   led_pattern_gen #(.WIDTH(8), .DIV(2)) u_a (
      .clk(clk), .rst(rst), .choose(choose), .hold(hold), .LED(led_a), .step(step_a)
   );

   led_pattern_gen #(.WIDTH(8), .DIV(1)) u_b (
      .clk(clk), .rst(rst), .choose(choose), .hold(hold), .LED(led_b), .step(step_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pattern after k steps in a mode, from the closed-form description of each mode.
   function automatic logic [7:0] pat(input int mode, input int k);
      int p;
      int g;
      case (mode)
         1: return 8'(1 << (k % 8));
         2: return 8'(128 >> (k % 8));
         3: return 8'(k % 256);
         4: return (k % 2 == 1) ? 8'h00 : 8'hFF;
         5: begin
            p = k % 14;
            if (p >= 8) p = 14 - p;
            return 8'(1 << p);
         end
         6: begin
            p = k % 9;
            return 8'((1 << p) - 1);
         end
         7: begin
            g = k % 256;
            return 8'(g ^ (g >> 1));
         end
         default: return 8'h00;
      endcase
   endfunction

   initial begin
      m_choose_q = 0;
      for (int i = 0; i < 2; i++) begin
         m_k[i] = 0; m_cnt[i] = 0; m_step[i] = 0;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m_choose_q = 0;
         for (int i = 0; i < 2; i++) begin
            m_k[i] = 0; m_cnt[i] = 0; m_step[i] = 0;
         end
      end else if (int'(choose) != m_choose_q) begin
         m_choose_q = int'(choose);
         for (int i = 0; i < 2; i++) begin
            m_k[i] = 0; m_cnt[i] = 0; m_step[i] = 0;
         end
      end else if (hold) begin
         for (int i = 0; i < 2; i++) m_step[i] = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_cnt[i] == divs[i] - 1) begin
               m_k[i]++; m_cnt[i] = 0; m_step[i] = 1;
            end else begin
               m_cnt[i]++; m_step[i] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_led_a",  led_a,  pat(m_choose_q, m_k[0]));
         chk("model_step_a", step_a, m_step[0]);
         chk("model_led_b",  led_b,  pat(m_choose_q, m_k[1]));
         chk("model_step_b", step_b, m_step[1]);
      end
   end

   // Each entry is shown for two cycles on the DIV=2 instance; first entry follows a mode change.
   task automatic run_seq(input string nm, input logic [7:0] e[$]);
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         chk({nm, "_led"}, led_a, e[i]);
         chk({nm, "_step"}, step_a, (i > 0));
         @(negedge clk);
         chk({nm, "_led2"}, led_a, e[i]);
         chk({nm, "_step2"}, step_a, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] gray[8];
      logic [2:0] mix[8];
      gray = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
      mix  = '{3'd5, 3'd7, 3'd2, 3'd0, 3'd4, 3'd6, 3'd3, 3'd1};

      rst = 1'b1; choose = 3'd0; hold = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_en = 1;
      chk("rst_led", led_a, 8'h00);
      chk("rst_step", step_a, 1'b0);

      rst = 1'b0; choose = 3'd1;
      q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      run_seq("rotl", q);

      choose = 3'd5;
      q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      run_seq("ping", q);

      choose = 3'd3;
      for (int j = 0; j <= 256; j++) begin
         @(negedge clk);
         chk("bin_b_led", led_b, j % 256);
         chk("bin_b_step", step_b, (j > 0));
      end
      choose = 3'd7;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk("gray_b_led", led_b, gray[j]);
      end

      choose = 3'd6;
      q = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
      run_seq("fill", q);
      hold = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk("hold_led", led_a, 8'h00);
         chk("hold_step", step_a, 1'b0);
      end
      hold = 1'b0;
      @(negedge clk);
      chk("resume_led", led_a, 8'h01);
      chk("resume_step", step_a, 1'b1);
      @(negedge clk);
      chk("resume_led2", led_a, 8'h01);

      choose = 3'd1;
      @(negedge clk);
      chk("sw_rotl_led", led_a, 8'h01);
      @(negedge clk);
      hold = 1'b1; choose = 3'd4;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("sw_blink_hold_led", led_a, 8'hFF);
         chk("sw_blink_hold_step", step_a, 1'b0);
      end
      hold = 1'b0;
      q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk("blink_led", led_a, q[j]);
         chk("blink_step", step_a, (j % 2 == 1));
      end

      choose = 3'd2;
      q = '{8'h80, 8'h40, 8'h20};
      run_seq("rotr", q);
      @(negedge clk);
      chk("rotr_led", led_a, 8'h10);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_led", led_a, 8'h00);
      chk("midrst_step", step_a, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_led", led_a, 8'h80);
      chk("postrst_step", step_a, 1'b0);

      for (int i = 0; i < 80; i++) begin
         choose = mix[(i / 10) % 8];
         hold   = (i % 7 == 3) || (i % 7 == 4);
         @(negedge clk);
      end
      hold = 1'b0;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
